clk_timeout_monitor: RTL and testbench



---
 rtl/clk_timeout_monitor.sv | 115 +++++++++++
 tb/tb_clk_timeout_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_timeout_monitor.sv
// rtl/clk_timeout_monitor.sv - glitch-filtered sticky timeout status with 4-phase alert handshake
module clk_timeout_monitor #(
  parameter int unsigned NumClk  = 4,
  parameter int unsigned FiltCnt = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumClk-1:0] en_i,
  input  logic [NumClk-1:0] timeout_i,
  input  logic [NumClk-1:0] clr_i,
  output logic [NumClk-1:0] status_o,
  output logic              any_timeout_o,
  output logic              alert_req_o,
  input  logic              alert_ack_i
);

  // Counter must hold values 0..FiltCnt.
  localparam int unsigned CntW = (FiltCnt + 1 <= 2) ? 1 : $clog2(FiltCnt + 1);
  localparam logic [CntW-1:0] FiltMax = CntW'(FiltCnt);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } state_e;

  logic [CntW-1:0]   cnt_q [NumClk];
  logic [NumClk-1:0] qual;
  logic [NumClk-1:0] status_q;
  logic              new_evt;
  logic              pending_q;
  state_e            state_q;

  // Per-channel saturating run-length counter of enabled high samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumClk; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NumClk; k++) begin
        if (en_i[k] && timeout_i[k]) begin
          if (cnt_q[k] != FiltMax) begin
            cnt_q[k] <= cnt_q[k] + CntW'(1);
          end
        end else begin
          cnt_q[k] <= '0;
        end
      end
    end
  end

  // Qualified level: the counter has seen FiltCnt consecutive highs.
  always_comb begin
    qual = '0;
    for (int unsigned k = 0; k < NumClk; k++) begin
      qual[k] = (cnt_q[k] == FiltMax);
    end
  end

  // Sticky status; a qualified timeout overrides a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= qual | (status_q & ~clr_i);
    end
  end

  // A channel whose status bit is about to rise is a new event.
  assign new_evt = |(qual & ~status_q);

  // Alert handshake FSM with coalescing pending flag; new events win over consume.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      alert_req_o <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pending_q) begin
            state_q     <= StReq;
            alert_req_o <= 1'b1;
            pending_q   <= new_evt;
          end else begin
            pending_q   <= new_evt;
          end
        end
        StReq: begin
          if (new_evt) pending_q <= 1'b1;
          if (alert_ack_i) begin
            state_q     <= StDrop;
            alert_req_o <= 1'b0;
          end
        end
        StDrop: begin
          if (new_evt) pending_q <= 1'b1;
          if (!alert_ack_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          alert_req_o <= 1'b0;
          pending_q   <= 1'b0;
        end
      endcase
    end
  end

  assign status_o      = status_q;
  assign any_timeout_o = |status_q;

endmodule

// File: tb/tb_clk_timeout_monitor.sv
// tb/tb_clk_timeout_monitor.sv - vector table, corner sequences and random stimulus vs reference model
module tb_clk_timeout_monitor;

  localparam int NCLK = 4;
  localparam int FILT = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NCLK-1:0] en_i = '0;
  logic [NCLK-1:0] timeout_i = '0;
  logic [NCLK-1:0] clr_i = '0;
  logic [NCLK-1:0] status_o;
  logic            any_timeout_o;
  logic            alert_req_o;
  logic            alert_ack_i = 1'b0;

  clk_timeout_monitor #(.NumClk(NCLK), .FiltCnt(FILT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .timeout_i    (timeout_i),
    .clr_i        (clr_i),
    .status_o     (status_o),
    .any_timeout_o(any_timeout_o),
    .alert_req_o  (alert_req_o),
    .alert_ack_i  (alert_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: run lengths of qualifying samples, sticky bits, handshake phase.
  int       run [NCLK];
  bit [3:0] m_status;
  bit       m_pend, m_req, m_wait;
  int       rises;
  bit       prev_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCLK; k++) run[k] = 0;
    m_status = '0;
    m_pend = 0;
    m_req = 0;
    m_wait = 0;
  endfunction

  function automatic void model_edge(input bit [3:0] en, input bit [3:0] to,
                                     input bit [3:0] clr, input bit ack);
    bit [3:0] q;
    bit evt;
    bit consume;
    consume = 0;
    for (int k = 0; k < NCLK; k++) q[k] = (run[k] >= FILT);
    evt = |(q & ~m_status);
    m_status = q | (m_status & ~clr);
    if (m_req) begin
      if (ack) begin m_req = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (!ack) m_wait = 0;
    end else if (m_pend) begin
      m_req = 1;
      consume = 1;
    end
    if (evt) m_pend = 1;
    else if (consume) m_pend = 0;
    for (int k = 0; k < NCLK; k++)
      run[k] = (en[k] && to[k]) ? ((run[k] < 1000) ? run[k] + 1 : run[k]) : 0;
  endfunction

  task automatic step(input logic [3:0] en, input logic [3:0] to,
                      input logic [3:0] clr, input logic ack);
    en_i = en;
    timeout_i = to;
    clr_i = clr;
    alert_ack_i = ack;
    @(posedge clk_i);
    model_edge(en, to, clr, ack);
    #1;
    chk("model_status", status_o, m_status);
    chk("model_any", any_timeout_o, |m_status);
    chk("model_req", alert_req_o, m_req);
    if (alert_req_o && !prev_req) rises++;
    prev_req = alert_req_o;
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] to;
    logic [3:0] clr;
    logic       ack;
    logic [3:0] st;
    logic       any;
    logic       req;
  } vec_t;

  vec_t tbl [22];
  int   r0;

  initial begin
    tbl[0]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0};
    tbl[6]  = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h1, 1'b1, 1'b0};
    tbl[7]  = '{4'hF, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[13] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[14] = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[15] = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[16] = '{4'hF, 4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[17] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0};
    tbl[18] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h4, 1'b1, 1'b1};
    tbl[19] = '{4'hF, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0};
    tbl[20] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0};
    tbl[21] = '{4'hF, 4'h0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0};

    model_reset();
    rises = 0;
    prev_req = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_status", status_o, 4'h0);
    chk("reset_any", any_timeout_o, 1'b0);
    chk("reset_req", alert_req_o, 1'b0);
    rst_ni = 1'b1;

    // Qualification timing and glitch filter
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].en, tbl[i].to, tbl[i].clr, tbl[i].ack);
      chk($sformatf("tbl%0d_status", i), status_o, tbl[i].st);
      chk($sformatf("tbl%0d_any", i), any_timeout_o, tbl[i].any);
      chk($sformatf("tbl%0d_req", i), alert_req_o, tbl[i].req);
    end

    // Clear is ineffective while the timeout persists
    repeat (3) step(4'hF, 4'h2, 4'h0, 1'b0);
    step(4'hF, 4'h2, 4'h0, 1'b0);
    chk("clrpri_set", status_o, 4'h2);
    step(4'hF, 4'h2, 4'h0, 1'b0);
    chk("clrpri_req", alert_req_o, 1'b1);
    step(4'hF, 4'h2, 4'h0, 1'b1);
    step(4'hF, 4'h2, 4'h0, 1'b0);
    step(4'hF, 4'h2, 4'h2, 1'b0);
    chk("clrpri_held", status_o, 4'h2);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h2, 1'b0);
    chk("clrpri_cleared", status_o, 4'h0);
    chk("clrpri_any", any_timeout_o, 1'b0);

    // Coalescing: two events during Req give exactly one further alert
    r0 = rises;
    repeat (3) step(4'hF, 4'h1, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("coal_in_req", alert_req_o, 1'b1);
    step(4'hF, 4'h0, 4'h1, 1'b0);
    step(4'hF, 4'h4, 4'h0, 1'b0);
    step(4'hF, 4'h4, 4'h0, 1'b0);
    step(4'hF, 4'hC, 4'h0, 1'b0);
    step(4'hF, 4'hC, 4'h0, 1'b0);
    step(4'hF, 4'hC, 4'h0, 1'b0);
    step(4'hF, 4'hC, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("coal_still_req", alert_req_o, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("coal_second_req", alert_req_o, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b1);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    repeat (4) step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("coal_rises", rises - r0, 2);
    chk("coal_status", status_o, 4'hC);
    step(4'hF, 4'h0, 4'hF, 1'b0);

    // Enable gating
    repeat (10) step(4'h7, 4'h8, 4'h0, 1'b0);
    chk("gate_status", status_o, 4'h0);
    chk("gate_req", alert_req_o, 1'b0);
    repeat (4) step(4'hF, 4'h8, 4'h0, 1'b0);
    chk("gate_set", status_o, 4'h8);
    step(4'hF, 4'h8, 4'h0, 1'b1);
    step(4'hF, 4'h8, 4'h0, 1'b0);
    repeat (3) step(4'h7, 4'h8, 4'h0, 1'b0);
    chk("gate_retain", status_o, 4'h8);
    step(4'h7, 4'h0, 4'hF, 1'b0);

    // Reset mid-handshake
    repeat (3) step(4'hF, 4'h5, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);
    chk("rst_pre_status", status_o, 4'h5);
    chk("rst_pre_req", alert_req_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_async_req", alert_req_o, 1'b0);
    chk("rst_async_status", status_o, 4'h0);
    chk("rst_async_any", any_timeout_o, 1'b0);
    model_reset();
    prev_req = 0;
    alert_ack_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) step(4'hF, 4'h0, 4'h0, 1'b1);
    chk("rst_stale_ack", alert_req_o, 1'b0);
    step(4'hF, 4'h0, 4'h0, 1'b0);

    // Randomized against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] en, to, clr;
      logic ack;
      en  = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
      to  = ~(4'($urandom) & 4'($urandom));
      clr = ($urandom % 6 == 0) ? 4'($urandom) : 4'h0;
      ack = ($urandom % 3 == 0);
      step(en, to, clr, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
